// File: rtl/letter_entry_buffer.sv
// Letter entry buffer: stores normalised upper-case key codes into DEPTH slots and
// issues a redraw handshake per change. Optional macro DUP_REJECT_EN refuses duplicate letters.
module letter_entry_buffer #(
    parameter int DEPTH = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 key_valid,
    input  logic [7:0]           key_code,
    input  logic                 backspace,
    input  logic                 draw_done,
    output logic [8*DEPTH-1:0]   letters,
    output logic [3:0]           letter_num,
    output logic                 draw_start,
    output logic                 busy,
    output logic                 full,
    output logic                 reject
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    function automatic logic key_legal(input logic [7:0] code);
        return ((code >= 8'h41) && (code <= 8'h5A)) ||
               ((code >= 8'h61) && (code <= 8'h7A));
    endfunction

    function automatic logic [7:0] key_norm(input logic [7:0] code);
        logic [7:0] res;
        if ((code >= 8'h61) && (code <= 8'h7A)) begin
            res = code - 8'h20;
        end else begin
            res = code;
        end
        return res;
    endfunction

    state_t      state_r;
    logic [7:0]  slot_r [DEPTH];
    logic [3:0]  count_r;
    logic        draw_start_r;
    logic        busy_r;
    logic        full_r;
    logic        reject_r;
    logic        pend_valid_r;
    logic        pend_del_r;
    logic [7:0]  pend_code_r;

    logic        in_any_s;
    logic        in_clash_s;
    logic        is_idle_s;
    logic        use_pend_s;
    logic        ev_valid_s;
    logic        ev_del_s;
    logic [7:0]  ev_code_s;
    logic [7:0]  ev_norm_s;
    logic        dup_s;
    logic        ev_store_ok_s;
    logic        ev_del_ok_s;
    logic        ev_refuse_s;
    logic        latch_req_s;
    logic        pend_free_s;
    logic        latch_ok_s;
    logic        drop_s;
    logic        reject_next_s;

    // Decode the incoming strobes; backspace has priority over a key in the same cycle.
    always_comb begin
        in_any_s   = key_valid | backspace;
        in_clash_s = key_valid & backspace;
        is_idle_s  = (state_r == ST_IDLE);
        use_pend_s = is_idle_s & pend_valid_r;
    end

    // Select the event to apply in IDLE: a held pending event beats a fresh strobe.
    always_comb begin
        ev_valid_s = is_idle_s & (pend_valid_r | in_any_s);
        if (pend_valid_r) begin
            ev_del_s  = pend_del_r;
            ev_code_s = pend_code_r;
        end else begin
            ev_del_s  = backspace;
            ev_code_s = key_code;
        end
        ev_norm_s = key_norm(ev_code_s);
    end

    // Duplicate detection; empty slots hold 0x00 which never matches a legal letter.
    always_comb begin
        dup_s = 1'b0;
`ifdef DUP_REJECT_EN
        for (int i = 0; i < DEPTH; i++) begin
            dup_s = dup_s | (slot_r[i] == ev_norm_s);
        end
`endif
    end

    // Accept/refuse decision and pending-register bookkeeping for this cycle.
    always_comb begin
        ev_store_ok_s = ev_valid_s & ~ev_del_s & key_legal(ev_code_s) &
                        (count_r != DEPTH_C) & ~dup_s;
        ev_del_ok_s   = ev_valid_s & ev_del_s & (count_r != 4'd0);
        ev_refuse_s   = ev_valid_s & ~(ev_store_ok_s | ev_del_ok_s);
        // A fresh strobe must be parked when busy or when the pending slot is being consumed.
        latch_req_s   = in_any_s & (~is_idle_s | use_pend_s);
        pend_free_s   = ~pend_valid_r | use_pend_s;
        latch_ok_s    = latch_req_s & pend_free_s;
        drop_s        = latch_req_s & ~pend_free_s;
        reject_next_s = ev_refuse_s | drop_s | in_clash_s;
    end

    // Main state machine, slot storage, pending register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            count_r      <= 4'd0;
            draw_start_r <= 1'b0;
            busy_r       <= 1'b0;
            full_r       <= 1'b0;
            reject_r     <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_del_r   <= 1'b0;
            pend_code_r  <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                slot_r[i] <= 8'h00;
            end
        end else begin
            reject_r <= reject_next_s;

            if (latch_ok_s) begin
                pend_valid_r <= 1'b1;
                pend_del_r   <= backspace;
                pend_code_r  <= key_code;
            end else if (use_pend_s) begin
                pend_valid_r <= 1'b0;
            end else begin
                pend_valid_r <= pend_valid_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (ev_store_ok_s | ev_del_ok_s) begin
                        state_r      <= ST_REQ;
                        draw_start_r <= 1'b1;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r      <= ST_IDLE;
                        draw_start_r <= 1'b0;
                        busy_r       <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (draw_done) begin
                        state_r      <= ST_WAIT;
                        draw_start_r <= 1'b0;
                    end else begin
                        state_r      <= ST_REQ;
                        draw_start_r <= 1'b1;
                    end
                    busy_r <= 1'b1;
                end
                ST_WAIT: begin
                    state_r      <= ST_IDLE;
                    draw_start_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    draw_start_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase

            // Store writes slot count_r; delete clears slot count_r-1.
            for (int i = 0; i < DEPTH; i++) begin
                if (ev_store_ok_s && (count_r == 4'(i))) begin
                    slot_r[i] <= ev_norm_s;
                end else if (ev_del_ok_s && (count_r == 4'(i + 1))) begin
                    slot_r[i] <= 8'h00;
                end else begin
                    slot_r[i] <= slot_r[i];
                end
            end

            if (ev_store_ok_s) begin
                count_r <= count_r + 4'd1;
                full_r  <= ((count_r + 4'd1) == DEPTH_C);
            end else if (ev_del_ok_s) begin
                count_r <= count_r - 4'd1;
                full_r  <= 1'b0;
            end else begin
                count_r <= count_r;
                full_r  <= full_r;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign letters[8*g +: 8] = slot_r[g];
    end

    assign letter_num = count_r;
    assign draw_start = draw_start_r;
    assign busy       = busy_r;
    assign full       = full_r;
    assign reject     = reject_r;

endmodule
